// File: rtl/restoring_divider_4bit.sv
// Sequential unsigned restoring divider: one shift-subtract iteration per clock,
// start/busy/done handshake, quotient of all ones when the divisor is zero.
module restoring_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    // The top bit of the partial remainder is always zero after an iteration,
    // so only the low WIDTH bits are stored; S and T are still WIDTH+1 bits.
    logic [WIDTH-1:0] r_reg, r_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   sub_a;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_borrow;

    assign sub_a = {r_reg, q_reg[WIDTH-1]};
    assign sub_b = {1'b0, d_reg};

    // Ripple borrow subtractor built from full-subtractor cells.
    always_comb begin
        logic bw;
        bw       = 1'b0;
        sub_diff = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (i < WIDTH) begin
                sub_diff[i] = sub_a[i] ^ sub_b[i] ^ bw;
            end
            bw = (~sub_a[i] & sub_b[i]) | (~(sub_a[i] ^ sub_b[i]) & bw);
        end
        sub_borrow = bw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            d_reg     <= d_next;
            r_reg     <= r_next;
            cnt_reg   <= cnt_next;
            dbz_reg   <= dbz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        r_next     = r_reg;
        cnt_next   = cnt_reg;
        dbz_next   = dbz_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    d_next   = divisor;
                    cnt_next = '0;
                    if (divisor == '0) begin
                        q_next     = '1;
                        r_next     = dividend;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        q_next     = dividend;
                        r_next     = '0;
                        dbz_next   = 1'b0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                busy   = 1'b1;
                q_next = {q_reg[WIDTH-2:0], ~sub_borrow};
                r_next = sub_borrow ? sub_a[WIDTH-1:0] : sub_diff;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign quotient    = q_reg;
    assign remainder   = r_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Scoreboard bench for restoring_divider_4bit: directed vectors, latency,
// ignored-start, async reset, back-to-back and a full nonzero-divisor sweep.
module tb_restoring_divider_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    restoring_divider_4bit #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   done_cnt = 0;
    int   issued_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input int a, input int b, input int q, input int r, input int z);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
        sb.push_back(e);
        issued_cnt++;
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got q=%0d r=%0d expected no done", quotient, remainder);
            end else begin
                mon_e = sb.pop_front();
                $display("done %0d/%0d -> q=%0d r=%0d dbz=%0d", mon_e.a, mon_e.b, quotient, remainder, div_by_zero);
                check("quotient", int'(quotient), mon_e.q);
                check("remainder", int'(remainder), mon_e.r);
                check("div_by_zero", int'(div_by_zero), mon_e.z);
                if (mon_e.b != 0) begin
                    check("invariant", int'(quotient) * mon_e.b + int'(remainder), mon_e.a);
                    check("rem_lt_div", int'(int'(remainder) < mon_e.b), 1);
                end
            end
        end
    end

    // Issues one operation; optionally checks busy/done timing relative to acceptance.
    task automatic do_div(input int a, input int b, input int q, input int r, input int z,
                          input bit chk_lat);
        int busy_n;
        int done_at;
        int done_n;
        @(negedge clk);
        dividend = 4'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        push_exp(a, b, q, r, z);
        @(negedge clk);
        start   = 1'b0;
        busy_n  = 0;
        done_at = 0;
        done_n  = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
        end
        if (chk_lat) begin
            check("busy_cycles", busy_n, (b != 0) ? 4 : 0);
            check("done_latency", done_at, (b != 0) ? 5 : 1);
            check("done_pulses", done_n, 1);
        end
    endtask

    initial begin
        int d0;
        int cyc;
        int nd;
        int times[3];

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;

        do_div(13, 3, 4, 1, 0, 1'b1);
        do_div(15, 1, 15, 0, 0, 1'b1);
        do_div(7, 9, 0, 7, 0, 1'b1);
        do_div(15, 15, 1, 0, 0, 1'b1);
        do_div(9, 0, 15, 9, 1, 1'b1);
        do_div(6, 2, 3, 0, 0, 1'b1);

        // Latched operands and ignored start pulses in CALC and DONE.
        d0 = done_cnt;
        @(negedge clk);
        dividend = 4'd14; divisor = 4'd4; start = 1'b1;
        push_exp(14, 4, 3, 2, 0);
        @(negedge clk);
        start = 1'b0; dividend = 4'd1; divisor = 4'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("latched_done_cycle", int'(done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("single_done_per_start", done_cnt - d0, 1);

        // Asynchronous reset two cycles into CALC.
        @(negedge clk);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_quotient", int'(quotient), 0);
        check("arst_remainder", int'(remainder), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        check("arst_held_busy", int'(busy), 0);
        rst_n = 1'b1;
        do_div(12, 5, 2, 2, 0, 1'b1);

        // Back-to-back with start held high.
        @(negedge clk);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(13, 3, 4, 1, 0);
        cyc = 0;
        nd  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                times[nd] = cyc;
                nd++;
                if (nd == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_done_count", nd, 3);
        if (nd == 3) begin
            check("b2b_gap1", times[1] - times[0], 6);
            check("b2b_gap2", times[2] - times[1], 6);
        end
        repeat (8) @(negedge clk);

        // Sweep of every nonzero-divisor pair.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_div(a, b, a / b, a % b, 0, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", done_cnt, issued_cnt);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
